// File: rtl/prio_sel_checker_pkg.sv
// Shared types, constants and the reference next-value function for the
// two-select priority byte mux checker.
package prio_sel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  // Widest data path the shared model function supports; callers cast down.
  localparam int unsigned MAX_DW = 64;

  localparam logic [MAX_DW-1:0] SEL_ONE = MAX_DW'(1);

  function automatic logic [MAX_DW-1:0] prio_next(
    input logic [MAX_DW-1:0] c,
    input logic              s1,
    input logic              s2,
    input logic [MAX_DW-1:0] hold
  );
    if (s1)      return c;
    else if (s2) return SEL_ONE;
    else         return hold;
  endfunction

endpackage

// File: rtl/prio_sel_checker_if.sv
// Stimulus/response bus seen by the checker: mux inputs, mux output and
// the checker's enable/clear controls.
interface prio_sel_checker_if #(
  parameter int unsigned DW = 8
);
  logic          en;
  logic          clr;
  logic [DW-1:0] c;
  logic          s1;
  logic          s2;
  logic [DW-1:0] dut_out;

  modport master (
    output en, clr, c, s1, s2, dut_out
  );

  modport slave (
    input en, clr, c, s1, s2, dut_out
  );
endinterface

// File: rtl/prio_sel_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prio_sel_checker.sv
// Response checker for the two-select priority byte mux: registered hold
// model, per-cycle compare in RUN, saturating statistics and a halt FSM.
module prio_sel_checker
  import prio_sel_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 4
) (
  input  logic                clk,
  input  logic                rst,
  prio_sel_checker_if.slave   bus,
  output logic [DW-1:0]       exp_out,
  output logic                mismatch,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    chk_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    hold_cnt,
  output logic [1:0]          state
);

  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(MAX_ERR - 1);

  chk_state_e    state_q, state_d;
  logic [DW-1:0] exp_q, exp_d;
  logic          mismatch_q, mismatch_d;
  logic          sticky_q, sticky_d;
  logic [DW-1:0] nxt;
  logic          cmp;
  logic          miss;
  logic          hold_inc;

  assign nxt = DW'(prio_next(MAX_DW'(bus.c), bus.s1, bus.s2, MAX_DW'(exp_q)));

  // The model register tracks in every state so the hold value stays valid.
  always_comb begin
    exp_d      = nxt;
    state_d    = state_q;
    sticky_d   = sticky_q;
    mismatch_d = 1'b0;
    cmp        = 1'b0;
    miss       = 1'b0;
    if (bus.clr) begin
      state_d  = IDLE;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) state_d = RUN;
        end
        RUN: begin
          if (!bus.en) begin
            state_d = IDLE;
          end else begin
            cmp  = 1'b1;
            miss = (bus.dut_out != nxt);
            if (miss) begin
              mismatch_d = 1'b1;
              sticky_d   = 1'b1;
              if (err_cnt >= ERR_LAST) state_d = HALT;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign hold_inc = cmp & ~bus.s1 & ~bus.s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (cmp),
    .cnt (chk_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (miss),
    .cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (hold_inc),
    .cnt (hold_cnt)
  );

  assign exp_out    = exp_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = sticky_q;
  assign state      = state_q;

endmodule

// File: tb/tb_prio_sel_checker.sv
// Directed plus randomized bench for prio_sel_checker against a behavioural
// model of the mux-hold rule, compare gating and saturating statistics.
module tb_prio_sel_checker;

  localparam int MAX_ERR  = 4;
  localparam int CNT_MAX  = 65535;
  localparam int CNT2_MAX = 15;

  logic clk;
  logic rst;

  prio_sel_checker_if #(.DW(8)) bus ();
  prio_sel_checker_if #(.DW(8)) bus2 ();

  logic [7:0]  exp_out, exp_out2;
  logic        mismatch, mismatch2;
  logic        err_sticky, err_sticky2;
  logic [15:0] chk_cnt, err_cnt, hold_cnt;
  logic [3:0]  chk_cnt2, err_cnt2, hold_cnt2;
  logic [1:0]  state, state2;

  prio_sel_checker #(.DW(8), .CNT_W(16), .MAX_ERR(MAX_ERR)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .exp_out    (exp_out),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .chk_cnt    (chk_cnt),
    .err_cnt    (err_cnt),
    .hold_cnt   (hold_cnt),
    .state      (state)
  );

  prio_sel_checker #(.DW(8), .CNT_W(4), .MAX_ERR(15)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .exp_out    (exp_out2),
    .mismatch   (mismatch2),
    .err_sticky (err_sticky2),
    .chk_cnt    (chk_cnt2),
    .err_cnt    (err_cnt2),
    .hold_cnt   (hold_cnt2),
    .state      (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = halted
  int         m_state;
  logic [7:0] m_exp;
  int         m_mis, m_sticky, m_chk, m_err, m_hold;

  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic logic [7:0] mux_value(input logic s1, input logic s2,
                                           input logic [7:0] c, input logic [7:0] prev);
    if (s1) return c;
    if (s2) return 8'd1;
    return prev;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 8'h00; m_mis = 0; m_sticky = 0;
    m_chk = 0; m_err = 0; m_hold = 0;
  endtask

  task automatic model_update(input logic en, input logic clr, input logic s1,
                              input logic s2, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] want;
    want  = mux_value(s1, s2, c, m_exp);
    m_mis = 0;
    if (clr) begin
      m_state = 0; m_sticky = 0; m_chk = 0; m_err = 0; m_hold = 0;
    end else if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      if (!en) begin
        m_state = 0;
      end else begin
        m_chk = sat_inc(m_chk, CNT_MAX);
        if (!s1 && !s2) m_hold = sat_inc(m_hold, CNT_MAX);
        if (d != want) begin
          m_mis    = 1;
          m_sticky = 1;
          m_err    = sat_inc(m_err, CNT_MAX);
          if (m_err >= MAX_ERR) m_state = 2;
        end
      end
    end
    m_exp = want;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".exp_out"},    32'(exp_out),    32'(m_exp));
    check({ctx, ".mismatch"},   32'(mismatch),   32'(m_mis));
    check({ctx, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    check({ctx, ".chk_cnt"},    32'(chk_cnt),    32'(m_chk));
    check({ctx, ".err_cnt"},    32'(err_cnt),    32'(m_err));
    check({ctx, ".hold_cnt"},   32'(hold_cnt),   32'(m_hold));
    check({ctx, ".state"},      32'(state),      32'(m_state));
  endtask

  task automatic step(input string ctx, input logic en, input logic clr, input logic s1,
                      input logic s2, input logic [7:0] c, input logic [7:0] d);
    bus.en = en; bus.clr = clr; bus.s1 = s1; bus.s2 = s2; bus.c = c; bus.dut_out = d;
    @(posedge clk);
    model_update(en, clr, s1, s2, c, d);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic       r_en, r_clr, r_s1, r_s2;
    logic [7:0] r_c, r_d, good, c2;

    rst = 1'b1;
    bus.en = 0; bus.clr = 0; bus.s1 = 0; bus.s2 = 0; bus.c = '0; bus.dut_out = '0;
    bus2.en = 0; bus2.clr = 0; bus2.s1 = 0; bus2.s2 = 0; bus2.c = '0; bus2.dut_out = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    step("enter_run", 1, 0, 0, 0, 8'h00, 8'h00);
    step("s1_match", 1, 0, 1, 0, 8'h5A, 8'h5A);
    check("plan_exp_5a", 32'(exp_out), 32'h5A);
    check("plan_chk_1", 32'(chk_cnt), 32'd1);
    step("s2_one", 1, 0, 0, 1, 8'h33, 8'h01);
    step("hold_one", 1, 0, 0, 0, 8'h33, 8'h01);
    check("plan_hold_1", 32'(hold_cnt), 32'd1);
    check("plan_hold_nomis", 32'(mismatch), 32'd0);
    step("both_sel", 1, 0, 1, 1, 8'h80, 8'h01);
    check("plan_both_mis", 32'(mismatch), 32'd1);
    check("plan_both_exp", 32'(exp_out), 32'h80);
    check("plan_both_err", 32'(err_cnt), 32'd1);

    step("clr1", 1, 1, 0, 0, 8'h00, 8'h00);
    check("plan_clr_keeps_exp", 32'(exp_out), 32'h80);
    step("rerun", 1, 0, 0, 0, 8'h00, 8'h80);
    for (int i = 0; i < 4; i++) begin
      step("wrong", 1, 0, 1, 0, 8'(i + 16), 8'(~(i + 16)));
    end
    check("plan_halt_state", 32'(state), 32'd2);
    check("plan_halt_err", 32'(err_cnt), 32'd4);
    step("halt_wrong", 1, 0, 1, 0, 8'h44, 8'h00);
    step("halt_en0", 0, 0, 0, 1, 8'h44, 8'h00);
    check("plan_halt_nopulse", 32'(mismatch), 32'd0);
    check("plan_halt_frozen", 32'(chk_cnt), 32'd4);
    step("clr2", 0, 1, 0, 0, 8'h00, 8'h00);
    check("plan_clr_idle", 32'(state), 32'd0);
    check("plan_clr_cnt", 32'(chk_cnt), 32'd0);

    step("pre_rst_a", 1, 0, 1, 0, 8'hC3, 8'hC3);
    step("pre_rst_b", 1, 0, 0, 0, 8'h00, 8'hC3);
    step("pre_rst_c", 1, 0, 0, 1, 8'h00, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    step("post_rst", 0, 0, 0, 0, 8'h00, 8'h00);

    for (int n = 0; n < 400; n++) begin
      r_en  = ($urandom_range(0, 9) != 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_s1  = 1'($urandom);
      r_s2  = 1'($urandom);
      r_c   = 8'($urandom);
      good  = mux_value(r_s1, r_s2, r_c, m_exp);
      r_d   = ($urandom_range(0, 5) == 0) ? (good ^ 8'($urandom_range(1, 255))) : good;
      step("rand", r_en, r_clr, r_s1, r_s2, r_c, r_d);
    end

    for (int k = 0; k <= 20; k++) begin
      c2 = 8'($urandom);
      bus2.en = 1; bus2.s1 = 1; bus2.s2 = 0; bus2.c = c2; bus2.dut_out = c2;
      @(posedge clk);
      #1;
      if (k > 0) begin
        check("small_chk", 32'(chk_cnt2), 32'((k > CNT2_MAX) ? CNT2_MAX : k));
        check("small_mis", 32'(mismatch2), 32'd0);
      end
    end
    check("small_sat_final", 32'(chk_cnt2), 32'd15);
    check("small_exp", 32'(exp_out2), 32'(c2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
